// File: rtl/dino_game_defs.sv
// Shared codes, sprite geometry and the danger/dino overlap test
// used by the collision and score logic.
package dino_game_defs;

  typedef enum logic [1:0] {
    GS_INIT,
    GS_START,
    GS_END,
    GS_RESET
  } game_state_e;

  typedef enum logic [2:0] {
    DT_LOW_BIRD,
    DT_HIGH_BIRD,
    DT_SMALL_CACTUS,
    DT_MANY_CACTUS,
    DT_BIG_CACTUS,
    DT_NONE
  } danger_type_e;

  typedef enum logic {
    DINO_SIT,
    DINO_STAND
  } posture_e;

  localparam logic [10:0] GROUND         = 11'd360;
  localparam logic [10:0] DINO_X         = 11'd40;
  localparam logic [10:0] DINO_W         = 11'd44;
  localparam logic [10:0] DINO_H_STAND   = 11'd47;
  localparam logic [10:0] DINO_H_SIT     = 11'd30;
  localparam logic [10:0] LOW_BIRD_LIFT  = 11'd12;
  localparam logic [10:0] HIGH_BIRD_LIFT = 11'd34;

  localparam logic [10:0] BIRD_W   = 11'd44;
  localparam logic [10:0] BIRD_H   = 11'd33;
  localparam logic [10:0] SMALL_W  = 11'd19;
  localparam logic [10:0] SMALL_H  = 11'd36;
  localparam logic [10:0] MANY_W   = 11'd77;
  localparam logic [10:0] MANY_H   = 11'd49;
  localparam logic [10:0] BIG_W    = 11'd27;
  localparam logic [10:0] BIG_H    = 11'd50;

  // Strict AABB overlap; left edge clamps at 0 instead of wrapping.
  function automatic logic overlap(
    input logic [9:0] pos,
    input logic [2:0] typ,
    input logic       en,
    input logic [9:0] dino_pos,
    input logic       stand
  );
    logic [10:0] w, h, bot, l, r, p, dh, dtop;
    logic        vld;
    vld = en;
    w   = '0;
    h   = '0;
    bot = GROUND;
    case (typ)
      DT_LOW_BIRD: begin
        w   = BIRD_W;
        h   = BIRD_H;
        bot = GROUND - LOW_BIRD_LIFT;
      end
      DT_HIGH_BIRD: begin
        w   = BIRD_W;
        h   = BIRD_H;
        bot = GROUND - HIGH_BIRD_LIFT;
      end
      DT_SMALL_CACTUS: begin
        w = SMALL_W;
        h = SMALL_H;
      end
      DT_MANY_CACTUS: begin
        w = MANY_W;
        h = MANY_H;
      end
      DT_BIG_CACTUS: begin
        w = BIG_W;
        h = BIG_H;
      end
      default: vld = 1'b0;
    endcase
    r    = {1'b0, pos};
    l    = (r < w) ? 11'd0 : r - w;
    p    = {1'b0, dino_pos};
    dh   = stand ? DINO_H_STAND : DINO_H_SIT;
    dtop = p - dh;
    return vld
      && (l < DINO_X + DINO_W)
      && (r > DINO_X)
      && (bot - h < p)
      && (dtop < bot);
  endfunction

endpackage

// File: rtl/dino_hit_score_bcd_counter4.sv
// Four-digit packed-BCD counter with synchronous clear and
// increment, holding at 9999.
module bcd_counter4 (
  input  logic        game_clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] nxt;
  logic        carry;

  always_comb begin
    nxt   = cnt;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (cnt[i*4 +: 4] == 4'd9) begin
          nxt[i*4 +: 4] = 4'd0;
        end else begin
          nxt[i*4 +: 4] = cnt[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != 16'h9999) begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/dino_hit_score.sv
// Collision detect against three danger slots, sticky hit flag,
// running BCD score and session high score.
module dino_hit_score
  import dino_game_defs::*;
#(
  parameter int SCORE_DIV = 8
) (
  input  logic        game_clk,
  input  logic        rst,
  input  logic [9:0]  dino_pos,
  input  logic        dino_behavior,
  input  logic [9:0]  danger_pos1,
  input  logic [9:0]  danger_pos2,
  input  logic [9:0]  danger_pos3,
  input  logic [2:0]  danger_type1,
  input  logic [2:0]  danger_type2,
  input  logic [2:0]  danger_type3,
  input  logic        danger_en1,
  input  logic        danger_en2,
  input  logic        danger_en3,
  input  logic [1:0]  game_state,
  output logic        hit,
  output logic        hit_pulse,
  output logic [15:0] score,
  output logic [15:0] hi_score
);

  localparam logic [7:0] DIV_LAST = 8'(SCORE_DIV - 1);

  logic [9:0] pos_q;
  logic       beh_q;
  logic [9:0] dpos_q [3];
  logic [2:0] dtyp_q [3];
  logic [2:0] den_q;
  logic [1:0] gs_q;
  logic [7:0] div;

  logic coll;
  logic hit_set;
  logic run;
  logic wrap;

  // Source clocks share a root, so one sample is enough.
  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      pos_q     <= '0;
      beh_q     <= 1'b0;
      dpos_q[0] <= '0;
      dpos_q[1] <= '0;
      dpos_q[2] <= '0;
      dtyp_q[0] <= '0;
      dtyp_q[1] <= '0;
      dtyp_q[2] <= '0;
      den_q     <= '0;
      gs_q      <= '0;
    end else begin
      pos_q     <= dino_pos;
      beh_q     <= dino_behavior;
      dpos_q[0] <= danger_pos1;
      dpos_q[1] <= danger_pos2;
      dpos_q[2] <= danger_pos3;
      dtyp_q[0] <= danger_type1;
      dtyp_q[1] <= danger_type2;
      dtyp_q[2] <= danger_type3;
      den_q     <= {danger_en3, danger_en2, danger_en1};
      gs_q      <= game_state;
    end
  end

  always_comb begin
    coll = overlap(dpos_q[0], dtyp_q[0], den_q[0], pos_q, beh_q)
         | overlap(dpos_q[1], dtyp_q[1], den_q[1], pos_q, beh_q)
         | overlap(dpos_q[2], dtyp_q[2], den_q[2], pos_q, beh_q);
  end

  assign run     = (gs_q == GS_START) && !hit;
  assign hit_set = coll && run;
  assign wrap    = run && (div == DIV_LAST);

  always_ff @(posedge game_clk or posedge rst) begin
    if (rst) begin
      hit       <= 1'b0;
      hit_pulse <= 1'b0;
      div       <= '0;
      hi_score  <= '0;
    end else begin
      hit_pulse <= hit_set;
      if (gs_q == GS_RESET) begin
        hit <= 1'b0;
        div <= '0;
      end else begin
        if (hit_set) hit <= 1'b1;
        if (run) div <= wrap ? 8'd0 : div + 8'd1;
      end
      // Packed BCD orders the same as plain unsigned.
      if (hit_set && score > hi_score) hi_score <= score;
    end
  end

  bcd_counter4 u_score (
    .game_clk (game_clk),
    .rst      (rst),
    .clr      (gs_q == GS_RESET),
    .inc      (wrap && !hit_set),
    .cnt      (score)
  );

endmodule
